// File: rtl/smart_store_pkg.sv
// Shared smart-store definitions: occupancy FSM states and default timing constants.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

package smart_store_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } occ_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES     = 16;
  localparam int DEF_WARMUP_CYCLES   = 8;
  localparam int DEF_COUNT_W         = 8;

  // Bits needed for a counter that runs 0 .. n-1 (never zero width).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module sync_debounce
  import smart_store_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic db
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // db flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 != db) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          db  <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pir_occupancy_detector.sv
// PIR front end: warm-up masking, retriggerable occupancy hold, motion pulse and event count.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module pir_occupancy_detector
  import smart_store_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int WARMUP_CYCLES   = DEF_WARMUP_CYCLES,
  parameter int COUNT_W         = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pir_raw,
  input  logic               clear_count,
  output logic               pir,
  output logic               motion_pulse,
  output logic               warming,
  output logic [COUNT_W-1:0] event_count
);

  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int WW = cnt_width(WARMUP_CYCLES);

  logic               db;
  occ_state_t         state;
  occ_state_t         state_nx;
  logic [HW-1:0]      hold_cnt;
  logic [HW-1:0]      hold_nx;
  logic [WW-1:0]      warm_cnt;
  logic [WW-1:0]      warm_nx;
  logic               start;
  logic [COUNT_W-1:0] count_nx;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk  (clk),
    .reset(reset),
    .din  (pir_raw),
    .db   (db)
  );

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    warm_nx  = warm_cnt;
    start    = 1'b0;
    case (state)
      ST_WARMUP: begin
        if (warm_cnt == WW'(WARMUP_CYCLES - 1)) begin
          warm_nx = '0;
          if (db) begin
            state_nx = ST_ACTIVE;
            start    = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          warm_nx = warm_cnt + WW'(1);
        end
      end
      ST_IDLE: begin
        if (db) begin
          state_nx = ST_ACTIVE;
          start    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!db) begin
          state_nx = ST_HOLD;
          hold_nx  = '0;
        end
      end
      ST_HOLD: begin
        // Retrigger takes priority over hold expiry.
        if (db) begin
          state_nx = ST_ACTIVE;
          start    = 1'b1;
        end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          state_nx = ST_IDLE;
        end else begin
          hold_nx = hold_cnt + HW'(1);
        end
      end
      default: state_nx = ST_WARMUP;
    endcase

    count_nx = event_count;
    if (clear_count) begin
      count_nx = '0;
    end else if (start && (event_count != {COUNT_W{1'b1}})) begin
      count_nx = event_count + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_WARMUP;
      hold_cnt     <= '0;
      warm_cnt     <= '0;
      pir          <= 1'b0;
      motion_pulse <= 1'b0;
      warming      <= 1'b1;
      event_count  <= '0;
    end else begin
      state        <= state_nx;
      hold_cnt     <= hold_nx;
      warm_cnt     <= warm_nx;
      pir          <= (state_nx == ST_ACTIVE) || (state_nx == ST_HOLD);
      motion_pulse <= start;
      warming      <= (state_nx == ST_WARMUP);
      event_count  <= count_nx;
    end
  end

endmodule

`default_nettype wire
